// File: rtl/fir_pkt_pkg.sv
// fir_pkt_pkg: shared FSM state type and header field layout for the FIR packetiser.
package fir_pkt_pkg;
  typedef enum logic [1:0] {IDLE, HEAD, DATA} state_t;
  localparam int SEQ_WD  = 32;
  localparam int HLEN_WD = 16;
  localparam int ENC_LSB = 0;
  // seq and len sit directly above the enc field, whose width is a block parameter
  function automatic int seq_lsb(input int head_wd);
    return head_wd;
  endfunction
  function automatic int len_lsb(input int head_wd);
    return head_wd + SEQ_WD;
  endfunction
endpackage

// File: rtl/fir_pkt_fifo.sv
// fir_pkt_fifo: first-word-fall-through FIFO; a write into a full FIFO is taken only alongside a pop.
module fir_pkt_fifo #(
  parameter int WD    = 576,
  parameter int DEPTH = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          wr,
  input  logic [WD-1:0] wdat,
  input  logic          rd,
  output logic [WD-1:0] rdat,
  output logic          full,
  output logic          empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WD-1:0] mem_q [DEPTH];
  logic [AW:0] wp_q, wp_d, rp_q, rp_d;
  logic do_wr, do_rd;
  assign empty = wp_q == rp_q;
  assign full  = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign do_rd = rd && !empty;
  assign do_wr = wr && (!full || do_rd);
  assign rdat  = mem_q[rp_q[AW-1:0]];
  always_comb begin
    wp_d = clr ? '0 : do_wr ? wp_q + (AW+1)'(1) : wp_q;
    rp_d = clr ? '0 : do_rd ? rp_q + (AW+1)'(1) : rp_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
    end
  end
  always_ff @(posedge clk) begin
    if (do_wr && !clr) mem_q[wp_q[AW-1:0]] <= wdat;
  end
endmodule

// File: rtl/fir_pkt_pack.sv
// fir_pkt_pack: buffers aligned FIR samples and emits header + pkt_len data beat packets on a ready/valid stream.
module fir_pkt_pack
  import fir_pkt_pkg::*;
#(
  parameter int DATA_WD    = 512,
  parameter int HEAD_WD    = 64,
  parameter int FIFO_DEPTH = 64,
  parameter int LEN_WD     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_rst,
  input  logic [LEN_WD-1:0]  pkt_len,
  input  logic               fir_ivld,
  input  logic [DATA_WD-1:0] fir_idat,
  input  logic [HEAD_WD-1:0] enc_idat,
  input  logic               m_tready,
  output logic               m_tvalid,
  output logic [DATA_WD-1:0] m_tdata,
  output logic               m_tsof,
  output logic               m_tlast,
  output logic               ovf_err,
  output logic [31:0]        pkt_cnt
);
  localparam int SEQ_LSB = seq_lsb(HEAD_WD);
  localparam int LEN_LSB = len_lsb(HEAD_WD);
  state_t state_q, state_d;
  logic [LEN_WD-1:0] len_q, len_d, beat_q, beat_d;
  logic [SEQ_WD-1:0] seq_q, seq_d, cnt_q, cnt_d;
  logic ovf_q, ovf_d;
  logic [DATA_WD+HEAD_WD-1:0] rdat;
  logic [DATA_WD-1:0] hdr;
  logic full, empty, pop, last;
  fir_pkt_fifo #(.WD(DATA_WD+HEAD_WD), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (cfg_rst),
    .wr    (fir_ivld),
    .wdat  ({enc_idat, fir_idat}),
    .rd    (pop),
    .rdat  (rdat),
    .full  (full),
    .empty (empty)
  );
  assign pop  = state_q == DATA && !empty && m_tready;
  assign last = beat_q == len_q - LEN_WD'(1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end
  always_comb begin
    state_d = cfg_rst             ? IDLE :
              state_q == IDLE     ? (empty ? IDLE : HEAD) :
              state_q == HEAD     ? (m_tready ? DATA : HEAD) :
              (pop && last)       ? IDLE : DATA;
  end
  always_comb begin
    hdr = '0;
    hdr[ENC_LSB +: HEAD_WD] = rdat[DATA_WD +: HEAD_WD];
    hdr[SEQ_LSB +: SEQ_WD]  = seq_q;
    hdr[LEN_LSB +: HLEN_WD] = HLEN_WD'(len_q);
    m_tvalid = state_q == HEAD || (state_q == DATA && !empty);
    m_tsof   = state_q == HEAD;
    m_tlast  = state_q == DATA && !empty && last;
    m_tdata  = state_q == HEAD ? hdr : state_q == DATA ? rdat[DATA_WD-1:0] : '0;
  end
  // a write into a full FIFO survives only when a pop frees the slot in the same cycle
  always_comb begin
    len_d  = len_q;
    beat_d = beat_q;
    seq_d  = seq_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q | (fir_ivld && full && !pop);
    if (cfg_rst) begin
      beat_d = '0;
      seq_d  = '0;
      cnt_d  = '0;
      ovf_d  = 1'b0;
    end else if (state_q == IDLE && !empty) begin
      len_d  = pkt_len == '0 ? LEN_WD'(1) : pkt_len;
      beat_d = '0;
    end else if (pop) begin
      beat_d = beat_q + LEN_WD'(1);
      seq_d  = last ? seq_q + SEQ_WD'(1) : seq_q;
      cnt_d  = last ? cnt_q + SEQ_WD'(1) : cnt_q;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q  <= '0;
      beat_q <= '0;
      seq_q  <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      len_q  <= len_d;
      beat_q <= beat_d;
      seq_q  <= seq_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
    end
  end
  assign ovf_err = ovf_q;
  assign pkt_cnt = cnt_q;
endmodule
